// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 host-side blocks (transmitter and receiver):
//   - ps2_tx_state_e : host transmit FSM states
//   - ps2_tx_dbg_t   : debug snapshot exported by the transmitter
//   - timing divisors that turn a clock frequency into PS/2 protocol times
//   - small helpers for cycle counts and odd parity
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  typedef struct packed {
    ps2_tx_state_e state;
    logic [3:0]    edge_cnt;
    logic          clk_fall;
    logic          data_fall;
  } ps2_tx_dbg_t;

  // 100 us clock-low inhibit = 1 s / 10_000.
  localparam int unsigned PS2_INHIBIT_DIV = 10_000;
  // ~15 ms max gap between device clock edges = 1 s / 66.
  localparam int unsigned PS2_TIMEOUT_DIV = 66;

  // Edge numbers within a host-to-device frame.
  localparam logic [3:0] PS2_PARITY_EDGE = 4'd9;
  localparam logic [3:0] PS2_STOP_EDGE   = 4'd10;
  localparam logic [3:0] PS2_ACK_EDGE    = 4'd11;

  function automatic int unsigned ps2_cycles(input int unsigned clk_freq,
                                             input int unsigned div);
    return clk_freq / div;
  endfunction

  // PS/2 parity makes the total count of ones (data + parity) odd.
  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync
// Two-flop synchronizer plus falling-edge detector for one raw PS/2 line.
// All flops reset to 1 (the idle level of an open-drain PS/2 line) so the
// first cycles after reset never report a falling edge.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous active-high reset
//   line_in   in  raw, asynchronous line level
//   line_sync out synchronized line level
//   line_fall out one-cycle pulse: previous synced 1, current synced 0
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_sync,
  output logic line_fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign line_sync = sync_q;
  assign line_fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// PS/2 host-to-device transmitter: sends one command byte to a keyboard
// (inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, ACK).
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   tx_data[7:0]            command byte
//   tx_valid / tx_ready     request handshake
//   ps2_clk_in, ps2_data_in raw PS/2 line levels (asynchronous)
//   ps2_clk_oe, ps2_data_oe 1 = pull the line low, 0 = release (open drain)
//   tx_done                 one-cycle pulse: byte sent and ACKed by device
//   tx_error                one-cycle pulse: missing ACK or edge timeout
//   dbg                     FSM state, edge count and line edge strobes
//
// Handshake: a byte is accepted on a rising clk edge where tx_valid and
// tx_ready are both high. tx_ready is high only in IDLE with reset low, so
// tx_valid outside IDLE is ignored and tx_data is only sampled at acceptance.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned INHIBIT_CYCLES = ps2_cycles(CLK_FREQ, PS2_INHIBIT_DIV),
  parameter int unsigned TIMEOUT_CYCLES = ps2_cycles(CLK_FREQ, PS2_TIMEOUT_DIV)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
  output logic        tx_done,
  output logic        tx_error,
  output ps2_tx_dbg_t dbg
);

  // One counter serves both the inhibit interval and the edge timeout.
  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       edge_q, edge_d;
  logic             bit_oe_q, bit_oe_d;
  logic [7:0]       byte_q;
  logic             parity_q;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             load;
  logic             clk_oe_c, data_oe_c;
  logic             timeout_hit;

  logic clk_sync, clk_fall;
  logic data_sync, data_fall;

  ps2_line_sync u_clk_sync (
    .clk       (clk),
    .reset     (reset),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync),
    .line_fall (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk       (clk),
    .reset     (reset),
    .line_in   (ps2_data_in),
    .line_sync (data_sync),
    .line_fall (data_fall)
  );

  assign tx_ready = (state_q == ST_IDLE) && !reset;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    bit_oe_d    = bit_oe_q;
    load        = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    clk_oe_c    = 1'b0;
    data_oe_c   = 1'b0;
    timeout_hit = (cnt_q == TO_LAST);

    case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        edge_d   = '0;
        bit_oe_d = 1'b0;
        if (tx_valid && tx_ready) begin
          load    = 1'b1;
          state_d = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        clk_oe_c = 1'b1;
        if (cnt_q == INH_LAST) begin
          // Start bit goes out while the clock is still held low.
          data_oe_c = 1'b1;
          state_d   = ST_RTS;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RTS: begin
        data_oe_c = 1'b1;
        if (clk_fall) begin
          state_d  = ST_SHIFT;
          edge_d   = 4'd1;
          bit_oe_d = ~byte_q[0];
          cnt_d    = '0;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        data_oe_c = bit_oe_q;
        if (clk_fall) begin
          // edge_q counts edges already seen; this edge is edge_q + 1.
          edge_d = edge_q + 4'd1;
          cnt_d  = '0;
          if (edge_q < 4'd8) begin
            bit_oe_d = ~byte_q[edge_q[2:0]];
          end else if (edge_q + 4'd1 == PS2_PARITY_EDGE) begin
            bit_oe_d = ~parity_q;
          end else begin
            bit_oe_d = 1'b0;
            state_d  = ST_ACK;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_ACK: begin
        if (clk_fall) begin
          edge_d = PS2_ACK_EDGE;
          cnt_d  = '0;
          if (!data_sync) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (clk_fall) begin
          cnt_d = '0;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      edge_q   <= '0;
      bit_oe_q <= 1'b0;
      byte_q   <= '0;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      bit_oe_q <= bit_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
      if (load) begin
        byte_q   <= tx_data;
        parity_q <= ps2_odd_parity(tx_data);
      end
    end
  end

  // Gated with reset so the lines are released for the whole reset pulse.
  assign ps2_clk_oe  = clk_oe_c & ~reset;
  assign ps2_data_oe = data_oe_c & ~reset;
  assign tx_done     = done_q;
  assign tx_error    = err_q;

  assign dbg.state     = state_q;
  assign dbg.edge_cnt  = edge_q;
  assign dbg.clk_fall  = clk_fall;
  assign dbg.data_fall = data_fall;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Bench for ps2_host_tx with a behavioural PS/2 keyboard on the far end of
// the open-drain lines (device clock period 40 cycles).
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 10;
  localparam int TO   = 200;
  localparam int HALF = 20;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT
  logic [7:0]  tx_data  = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        ps2_clk_in, ps2_data_in;
  logic        ps2_clk_oe, ps2_data_oe;
  logic        tx_done, tx_error;
  ps2_tx_dbg_t dbg;

  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .dbg         (dbg)
  );

  // scoreboard
  logic [9:0] exp_q[$];   // {stop, parity, data} per frame
  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  bit ack_phase = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_done)  done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) check("done_err_exclusive", 1, 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200 && !tx_ready; i++) tick(1);
    check("ready_before_send", tx_ready, 1);
  endtask

  task automatic send(input logic [7:0] b, input bit push);
    wait_ready();
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom_range(0, 255));
    if (push) exp_q.push_back({1'b1, ~^b, b});
  endtask

  task automatic wait_rts(output int inh, output int rts_cyc);
    bit ok;
    inh = 0;
    ok  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!ps2_clk_oe && ps2_data_oe) begin
        ok = 1'b1;
        break;
      end
      if (ps2_clk_oe) inh++;
      tick(1);
    end
    rts_cyc = cyc;
    check("rts_reached", ok, 1);
  endtask

  // Keyboard side: n clock pulses; samples host data just before each rising
  // edge after falls 1..10, optionally drives ACK low around the 11th fall.
  task automatic dev_frame(input int n, input bit ack, output logic [9:0] bits);
    bits = '0;
    tick(HALF);
    for (int k = 1; k <= n; k++) begin
      if (k == 11) begin
        ack_phase = 1'b1;
        if (ack) dev_data = 1'b0;
        tick(5);
      end
      dev_clk = 1'b0;
      tick(HALF);
      if (k <= 10) bits[k-1] = ps2_data_in;
      dev_clk = 1'b1;
      tick(HALF);
    end
    dev_data = 1'b1;
  endtask

  task automatic pop_compare(input string tag, input logic [9:0] bits);
    logic [9:0] exp;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_bits"}, bits, exp);
    end
  endtask

  task automatic frame_test(input string tag, input logic [7:0] b, input bit ack,
                            output logic [9:0] bits);
    int inh, rts_cyc, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send(b, 1'b1);
    wait_rts(inh, rts_cyc);
    check({tag, "_inhibit_len"}, inh, INH);
    check({tag, "_start_bit"}, ps2_data_in, 0);
    dev_frame(11, ack, bits);
    tick(10);
    pop_compare(tag, bits);
    check({tag, "_done_pulses"}, done_cnt - d0, ack ? 1 : 0);
    check({tag, "_err_pulses"}, err_cnt - e0, ack ? 0 : 1);
    check({tag, "_lines_released"}, {ps2_clk_oe, ps2_data_oe}, 0);
    check({tag, "_ready_after"}, tx_ready, 1);
  endtask

  initial begin
    logic [9:0] bits;
    int inh, rts_cyc, d0, e0, seen;

    // reset state
    reset = 1'b1;
    tick(3);
    check("rst_ready", tx_ready, 0);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_pulses", {tx_done, tx_error}, 0);
    reset = 1'b0;
    tick(1);
    check("post_rst_ready", tx_ready, 1);

    // 0xED: data 1,0,1,1,0,1,1,1 then parity 1, stop 1
    frame_test("ed", 8'hED, 1'b1, bits);
    check("ed_literal", bits, 10'b1_1_1110_1101);

    // 0xF4: parity 0
    frame_test("f4", 8'hF4, 1'b1, bits);
    check("f4_parity", bits[8], 0);

    // 0x00 with no ACK
    frame_test("nack", 8'h00, 1'b0, bits);

    // random bytes
    for (int i = 0; i < 2; i++) begin
      frame_test("rnd", 8'($urandom_range(0, 255)), 1'b1, bits);
    end

    // device never clocks: timeout measured from RTS entry
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hFF, 1'b0);
    wait_rts(inh, rts_cyc);
    for (int i = 0; i < 400 && !tx_error; i++) tick(1);
    check("to_latency", cyc - rts_cyc, TO);
    check("to_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    tick(5);
    check("to_err_pulses", err_cnt - e0, 1);
    check("to_done_pulses", done_cnt - d0, 0);

    // reset after the 5th falling edge
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h0F, 1'b0);
    wait_rts(inh, rts_cyc);
    dev_frame(5, 1'b0, bits);
    check("mid_data_oe", ps2_data_oe, 1);
    reset = 1'b1;
    tick(1);
    check("mid_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("mid_rst_ready", tx_ready, 0);
    reset = 1'b0;
    tick(1);
    check("mid_rst_ready_after", tx_ready, 1);
    tick(20);
    check("mid_rst_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

    // tx_valid held with tx_data toggling: one frame with the latched byte
    d0 = done_cnt;
    ack_phase = 1'b0;
    wait_ready();
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick(1);
    exp_q.push_back({1'b1, ~^tx_data, tx_data});
    fork
      begin
        while (!ack_phase) begin
          tx_data = 8'($urandom_range(0, 255));
          tick(1);
        end
        tx_valid = 1'b0;
      end
      begin
        wait_rts(inh, rts_cyc);
        check("held_inhibit_len", inh, INH);
        dev_frame(11, 1'b1, bits);
      end
    join
    tick(10);
    pop_compare("held", bits);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (ps2_clk_oe) seen++;
      tick(1);
    end
    check("held_no_second_frame", seen, 0);
    check("held_done_pulses", done_cnt - d0, 1);

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter INHIBIT_CYCLES, default CLK_FREQ/10_000 (100 us), the clock-low inhibit time.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default CLK_FREQ/66 (~15 ms), the maximum gap between device clock falling edges.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tx_data  input  8  command byte to send to keyboard.
REQ-007 tx_valid  input  1  request; byte accepted when tx_valid && tx_ready.
REQ-008 tx_ready  output  1  high only in IDLE with reset low.
REQ-009 ps2_clk_in  input  1  raw PS/2 clock line level (asynchronous).
REQ-010 ps2_data_in  input  1  raw PS/2 data line level (asynchronous).
REQ-011 ps2_clk_oe  output  1  1 = pull clock line low; 0 = release (open drain).
REQ-012 ps2_data_oe  output  1  1 = pull data line low; 0 = release.
REQ-013 tx_done  output  1  one-cycle pulse: byte sent and acknowledged.
REQ-014 tx_error  output  1  one-cycle pulse: no ACK or timeout.

Function
REQ-015 Both PS/2 inputs SHALL pass a 2-FF synchronizer; falling edge = previous synced 1 and current synced 0.
REQ-016 States SHALL be IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
REQ-017 On acceptance: latch tx_data, compute odd parity (parity = ~^tx_data), enter INHIBIT next cycle.
REQ-018 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for INHIBIT_CYCLES cycles; on the last cycle assert ps2_data_oe and go to RTS.
REQ-019 RTS: ps2_clk_oe=0, ps2_data_oe=1 (start bit 0); wait for first device clock falling edge.
REQ-020 SHIFT: on falling edges 1..8 drive data bits LSB first, 9th parity, 10th stop (ps2_data_oe=0); ps2_data_oe = ~bit, updated the cycle after the edge is detected.
REQ-021 After 10th edge SHALL go to ACK; on 11th falling edge sample synced data: 0 -> WAIT_IDLE, 1 -> tx_error pulse, IDLE.
REQ-022 WAIT_IDLE: when synced clock and data both 1, pulse tx_done, return to IDLE.
REQ-023 In RTS, SHIFT, ACK, WAIT_IDLE a counter SHALL clear on every falling edge and state entry; reaching TIMEOUT_CYCLES -> both oe=0, tx_error pulse, IDLE.
REQ-024 tx_valid while not IDLE SHALL be ignored; tx_data changes after acceptance SHALL not affect the frame.
REQ-025 Acceptance while the device is transmitting SHALL proceed (inhibit aborts device frame, per PS/2).
REQ-026 tx_done and tx_error SHALL never be high in the same cycle.
REQ-027 Edge counter SHALL be 4 bits and SHALL NOT wrap; only values 0..11 are used.

Reset
REQ-028 Reset SHALL force IDLE; ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_error=0, tx_ready=0 while reset high.
REQ-029 Reset mid-frame SHALL release both lines on the next clk edge; no done/error pulse.
REQ-030 Synchronizer flops SHALL reset to 1 (idle line) so no spurious falling edge follows reset.

Structure
REQ-031 Shared package ps2_pkg SHALL hold the state enum and PS/2 timing constants (100 us inhibit, 15 ms timeout).
REQ-032 Sub-module ps2_line_sync (2-FF sync + falling-edge detect) SHALL be used, shared with the PS/2 receiver.

Verification (bench: INHIBIT_CYCLES=10, TIMEOUT_CYCLES=200, device model clocks every 40 cycles)
REQ-033 Send 0xED -> clk_oe high 10 cycles; data sequence 0,1,0,1,1,0,1,1,1, parity 1, stop 1; model ACKs -> tx_done once.
REQ-034 Send 0xF4 -> parity bit 0; tx_done; tx_ready high again after WAIT_IDLE.
REQ-035 Send 0x00, model holds data high on 11th edge -> tx_error one pulse, no tx_done, lines released.
REQ-036 Send 0xFF, model never clocks -> tx_error exactly 200 cycles after RTS entry, both oe=0.
REQ-037 Reset pulsed after 5th falling edge -> both oe=0 next cycle, no pulses, tx_ready=1 after reset drops.
REQ-038 tx_valid held high throughout a frame with tx_data toggling -> exactly one frame with the originally latched byte.
